hazard_unit_mc: RTL and testbench

//  Pipeline hazard/stall controller for the 5-stage MIPS core; the producer of the EN/CLR controls consumed by
//  the IF/ID instruction register (EN = load, priority over CLR; CLR = clear to 0 when EN low).

---
 rtl/hazard_unit_mc.sv | 115 +++++++++++
 tb/tb_hazard_unit_mc.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
// Hazard/stall controller for the 5-stage MIPS pipeline.
// Load-use, branch-compare and HI/LO hazards, forwarding, mult/div busy count.
module hazard_unit_mc #(
  parameter int WIDTH_5    = 5,
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH_5-1:0] RS_D,
  input  logic [WIDTH_5-1:0] RT_D,
  input  logic [WIDTH_5-1:0] RS_E,
  input  logic [WIDTH_5-1:0] RT_E,
  input  logic [WIDTH_5-1:0] WRITE_REG_E,
  input  logic [WIDTH_5-1:0] WRITE_REG_M,
  input  logic [WIDTH_5-1:0] WRITE_REG_W,
  input  logic               REG_WRITE_E,
  input  logic               REG_WRITE_M,
  input  logic               REG_WRITE_W,
  input  logic               MEM_TO_REG_E,
  input  logic               MEM_TO_REG_M,
  input  logic               BRANCH_D,
  input  logic               PC_SRC_D,
  input  logic               MD_D,
  input  logic               MFHILO_D,
  input  logic               MD_START_E,
  output logic               STALL_F,
  output logic               EN_D,
  output logic               CLR_D,
  output logic               FLUSH_E,
  output logic               FWD_A_D,
  output logic               FWD_B_D,
  output logic [1:0]         FWD_A_E,
  output logic [1:0]         FWD_B_E,
  output logic               MD_BUSY
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lw_stall, br_stall, md_stall, stall;

  function automatic logic match(
    input logic [WIDTH_5-1:0] x,
    input logic [WIDTH_5-1:0] r,
    input logic               we
  );
    return we && (r != '0) && (r == x);
  endfunction

  function automatic logic [1:0] fwd_e(
    input logic [WIDTH_5-1:0] src
  );
    if (match(src, WRITE_REG_M, REG_WRITE_M))
      return 2'b10;
    else if (match(src, WRITE_REG_W, REG_WRITE_W))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign MD_BUSY = (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (MD_START_E)
      cnt_d = CNT_W'(MD_LATENCY);
    else if (cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    lw_stall = MEM_TO_REG_E &
      (match(RS_D, WRITE_REG_E, REG_WRITE_E) |
       match(RT_D, WRITE_REG_E, REG_WRITE_E));
    br_stall = BRANCH_D &
      (match(RS_D, WRITE_REG_E, REG_WRITE_E) |
       match(RT_D, WRITE_REG_E, REG_WRITE_E) |
       (MEM_TO_REG_M &
        (match(RS_D, WRITE_REG_M, REG_WRITE_M) |
         match(RT_D, WRITE_REG_M, REG_WRITE_M))));
    md_stall = (MFHILO_D | MD_D) & (MD_BUSY | MD_START_E);
    stall    = lw_stall | br_stall | md_stall;
  end

  // IF/ID gives EN priority over CLR, so any flush must drop EN.
  always_comb begin
    STALL_F = 1'b0;
    EN_D    = 1'b1;
    CLR_D   = 1'b0;
    FLUSH_E = 1'b0;
    FWD_A_D = 1'b0;
    FWD_B_D = 1'b0;
    FWD_A_E = 2'b00;
    FWD_B_E = 2'b00;
    if (rst_n) begin
      if (stall) begin
        STALL_F = 1'b1;
        EN_D    = 1'b0;
        FLUSH_E = 1'b1;
      end else if (PC_SRC_D) begin
        EN_D    = 1'b0;
        CLR_D   = 1'b1;
      end
      FWD_A_D = match(RS_D, WRITE_REG_M, REG_WRITE_M);
      FWD_B_D = match(RT_D, WRITE_REG_M, REG_WRITE_M);
      FWD_A_E = fwd_e(RS_E);
      FWD_B_E = fwd_e(RT_E);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: directed vectors plus a
// constrained random phase checked against a behavioural model.
module tb_hazard_unit_mc;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, pcs_d;
  logic md_d, mfhilo_d, md_start;
  logic stall_f, en_d, clr_d, flush_e, fad, fbd, busy;
  logic [1:0] fae, fbe;

  typedef struct {
    string       name;
    logic [10:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt_m  = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(.WIDTH_5(5), .MD_LATENCY(LAT), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .RS_D(rs_d), .RT_D(rt_d), .RS_E(rs_e), .RT_E(rt_e),
    .WRITE_REG_E(wr_e), .WRITE_REG_M(wr_m), .WRITE_REG_W(wr_w),
    .REG_WRITE_E(rw_e), .REG_WRITE_M(rw_m), .REG_WRITE_W(rw_w),
    .MEM_TO_REG_E(m2r_e), .MEM_TO_REG_M(m2r_m),
    .BRANCH_D(br_d), .PC_SRC_D(pcs_d),
    .MD_D(md_d), .MFHILO_D(mfhilo_d), .MD_START_E(md_start),
    .STALL_F(stall_f), .EN_D(en_d), .CLR_D(clr_d),
    .FLUSH_E(flush_e), .FWD_A_D(fad), .FWD_B_D(fbd),
    .FWD_A_E(fae), .FWD_B_E(fbe), .MD_BUSY(busy)
  );

  task automatic clr_in();
    {rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w} = '0;
    {rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, pcs_d} = '0;
    {md_d, mfhilo_d, md_start} = '0;
  endtask

  task automatic expo(input string n,
    input logic st, input logic en, input logic cl, input logic fl,
    input logic ad, input logic bd,
    input logic [1:0] ae, input logic [1:0] be, input logic b);
    exp_t e;
    e.name = n;
    e.v = {st, en, cl, fl, ad, bd, ae, be, b};
    q.push_back(e);
  endtask

  // Model counter advances on each rising edge, then inputs change.
  task automatic step();
    @(posedge clk);
    if (!rst_n) cnt_m = 0;
    else if (md_start) cnt_m = LAT;
    else if (cnt_m != 0) cnt_m--;
    #1;
  endtask

  function automatic logic hit(input logic [4:0] x,
    input logic [4:0] r, input logic we);
    return we && r != 5'd0 && r == x;
  endfunction

  function automatic logic [10:0] model();
    logic lw, br, md, st, en, cl, ad, bd;
    logic [1:0] ae, be;
    lw = m2r_e && (hit(rs_d, wr_e, rw_e) || hit(rt_d, wr_e, rw_e));
    br = br_d && (hit(rs_d, wr_e, rw_e) || hit(rt_d, wr_e, rw_e) ||
         (m2r_m && (hit(rs_d, wr_m, rw_m) || hit(rt_d, wr_m, rw_m))));
    md = (mfhilo_d || md_d) && (cnt_m != 0 || md_start);
    st = lw || br || md;
    en = !st && !pcs_d;
    cl = !st && pcs_d;
    ad = hit(rs_d, wr_m, rw_m);
    bd = hit(rt_d, wr_m, rw_m);
    ae = hit(rs_e, wr_m, rw_m) ? 2'b10 :
         hit(rs_e, wr_w, rw_w) ? 2'b01 : 2'b00;
    be = hit(rt_e, wr_m, rw_m) ? 2'b10 :
         hit(rt_e, wr_w, rw_w) ? 2'b01 : 2'b00;
    return {st, en, cl, st, ad, bd, ae, be, cnt_m != 0};
  endfunction

  always @(negedge clk) begin
    logic [10:0] got;
    exp_t e;
    got = {stall_f, en_d, clr_d, flush_e, fad, fbd, fae, fbe, busy};
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL %s: got %b required %b", e.name, got, e.v);
      end
      checks++;
      if ((en_d & clr_d) || stall_f !== flush_e ||
          stall_f !== (~en_d & ~clr_d)) begin
        errors++;
        $display("FAIL %s_encode: got st=%b en=%b clr=%b fl=%b",
                 e.name, stall_f, en_d, clr_d, flush_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clr_in();
    rs_e = 5'd5; wr_m = 5'd5; rw_m = 1'b1;
    m2r_e = 1'b1; rw_e = 1'b1; wr_e = 5'd8; rs_d = 5'd8;
    #1;
    expo("reset", 0,1,0,0, 0,0, 2'b00,2'b00, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    clr_in();

    step(); clr_in();
    m2r_e = 1; rw_e = 1; wr_e = 5'd8; rs_d = 5'd8;
    expo("lw_rs", 1,0,0,1, 0,0, 2'b00,2'b00, 0);
    step(); clr_in();
    m2r_e = 1; rw_e = 1; wr_e = 5'd0; rs_d = 5'd0;
    expo("lw_r0", 0,1,0,0, 0,0, 2'b00,2'b00, 0);
    step(); clr_in();
    m2r_e = 1; rw_e = 1; wr_e = 5'd8; rt_d = 5'd8; rs_d = 5'd3;
    expo("lw_rt", 1,0,0,1, 0,0, 2'b00,2'b00, 0);

    step(); clr_in();
    wr_m = 5'd5; wr_w = 5'd5; rw_m = 1; rw_w = 1; rs_e = 5'd5;
    expo("fwd_m", 0,1,0,0, 0,0, 2'b10,2'b00, 0);
    step(); clr_in();
    wr_m = 5'd5; wr_w = 5'd5; rw_w = 1; rs_e = 5'd5;
    expo("fwd_w", 0,1,0,0, 0,0, 2'b01,2'b00, 0);
    step(); clr_in();
    wr_m = 5'd5; wr_w = 5'd5; rw_m = 1; rw_w = 1;
    rs_e = 5'd5; rt_e = 5'd6;
    expo("fwd_none", 0,1,0,0, 0,0, 2'b10,2'b00, 0);
    step(); clr_in();
    wr_m = 5'd5; rw_m = 1; rs_d = 5'd5; rt_d = 5'd5;
    expo("fwd_d", 0,1,0,0, 1,1, 2'b00,2'b00, 0);
    step(); clr_in();
    wr_m = 5'd0; rw_m = 1; wr_w = 5'd0; rw_w = 1;
    expo("fwd_r0", 0,1,0,0, 0,0, 2'b00,2'b00, 0);

    step(); clr_in();
    br_d = 1; pcs_d = 1; rs_d = 5'd9; rt_d = 5'd10;
    expo("br_taken", 0,0,1,0, 0,0, 2'b00,2'b00, 0);
    step(); clr_in();
    br_d = 1; pcs_d = 1; rs_d = 5'd9; rt_d = 5'd10;
    rw_e = 1; wr_e = 5'd9;
    expo("br_stall_e", 1,0,0,1, 0,0, 2'b00,2'b00, 0);
    step(); clr_in();
    br_d = 1; rs_d = 5'd9; rt_d = 5'd10;
    m2r_m = 1; rw_m = 1; wr_m = 5'd10;
    expo("br_stall_m", 1,0,0,1, 0,1, 2'b00,2'b00, 0);
    step(); clr_in();
    br_d = 1; rs_d = 5'd9; rt_d = 5'd10; rw_m = 1; wr_m = 5'd10;
    expo("br_fwd_m", 0,1,0,0, 0,1, 2'b00,2'b00, 0);

    step(); clr_in();
    md_start = 1; mfhilo_d = 1;
    expo("md_issue", 1,0,0,1, 0,0, 2'b00,2'b00, 0);
    for (int i = 1; i <= LAT; i++) begin
      step(); clr_in();
      mfhilo_d = 1;
      expo($sformatf("md_busy%0d", i), 1,0,0,1, 0,0, 2'b00,2'b00, 1);
    end
    step(); clr_in();
    mfhilo_d = 1;
    expo("md_done", 0,1,0,0, 0,0, 2'b00,2'b00, 0);

    step(); clr_in();
    md_start = 1; md_d = 1;
    expo("rst_issue", 1,0,0,1, 0,0, 2'b00,2'b00, 0);
    step(); clr_in();
    md_d = 1;
    expo("rst_busy1", 1,0,0,1, 0,0, 2'b00,2'b00, 1);
    step(); clr_in();
    md_d = 1; rst_n = 1'b0; cnt_m = 0;
    expo("rst_async", 0,1,0,0, 0,0, 2'b00,2'b00, 0);
    step(); clr_in();
    md_d = 1; rst_n = 1'b1;
    expo("rst_release", 0,1,0,0, 0,0, 2'b00,2'b00, 0);
    step(); clr_in();
    md_d = 1;
    expo("rst_after", 0,1,0,0, 0,0, 2'b00,2'b00, 0);

    for (int n = 0; n < 2000; n++) begin
      exp_t e;
      step();
      rs_d = 5'($urandom_range(0, 7)); rt_d = 5'($urandom_range(0, 7));
      rs_e = 5'($urandom_range(0, 7)); rt_e = 5'($urandom_range(0, 7));
      wr_e = 5'($urandom_range(0, 7)); wr_m = 5'($urandom_range(0, 7));
      wr_w = 5'($urandom_range(0, 7));
      {rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, pcs_d} = 7'($urandom);
      {md_d, mfhilo_d} = 2'($urandom);
      md_start = ($urandom_range(0, 15) == 0);
      e.name = "rand";
      e.v = model();
      q.push_back(e);
    end

    step(); clr_in();
    step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
